// File: rtl/gf_result_deserializer.sv
// Assembles bit-serial GF(2^M) product coefficients into an aligned word q[1:M]; q is valid 1 cycle after c[M].
// Backpressure: a completed word waits in the assembly reg (FULL, in_ready=0) until q is drained.
module gf_result_deserializer #(
  parameter int M     = 31,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_start,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:M] q,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:M]       sr;
  logic             accept;
  logic             drain;

  assign in_ready = !rst && (state != FULL);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign cnt_nxt  = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      q         <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      // A completion or FULL drain below re-asserts out_valid in the same cycle.
      if (drain) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (in_start) begin
              sr[1] <= in_bit;
              cnt   <= CNT_W'(1);
              state <= COLLECT;
            end else begin
              err <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            if (in_start) begin
              sr[1] <= in_bit;
              cnt   <= CNT_W'(1);
              err   <= 1'b1;
            end else if (cnt == CNT_W'(M - 1)) begin
              sr[M] <= in_bit;
              if (!out_valid || out_ready) begin
                q         <= {sr[1:M-1], in_bit};
                out_valid <= 1'b1;
                cnt       <= '0;
                state     <= IDLE;
              end else begin
                state <= FULL;
              end
            end else begin
              sr[cnt_nxt] <= in_bit;
              cnt         <= cnt_nxt;
            end
          end
        end

        FULL: begin
          if (drain) begin
            q         <= sr;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_result_deserializer.sv
// Directed and randomized bench for gf_result_deserializer with an in-order word scoreboard.
module tb_gf_result_deserializer;
  localparam int M  = 31;
  localparam int NF = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_start;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:M] q;
  logic       err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:M] expq[$];

  gf_result_deserializer #(.M(M), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one coefficient and returns just after the edge that accepts it.
  task automatic send_bit(input logic b, input logic s);
    int guard = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_start = s;
    while (!in_ready && guard < 2000) begin
      tick();
      guard++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_word(input logic [1:M] w);
    for (int k = 1; k <= M; k++) send_bit(w[k], k == 1);
  endtask

  initial begin
    logic [1:M] wa, wb, wr, alt;
    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_q", 64'(q), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1: alternating 1,0,... with consumer always ready
    out_ready = 1'b1;
    for (int k = 1; k <= M; k++) alt[k] = (k % 2 == 1);
    for (int k = 1; k < M; k++) send_bit(alt[k], k == 1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_not_early", 64'(out_valid), 64'd0);
    send_bit(alt[M], 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_q", 64'(q), 64'h55555555);
    check("t1_busy_idle", 64'(busy), 64'd0);
    tick();
    check("t1_drained", 64'(out_valid), 64'd0);
    check("t1_q_kept", 64'(q), 64'h55555555);

    // 2: back-to-back frames with consumer stalled
    out_ready = 1'b0;
    wa = 31'h12345678;
    wb = 31'h7ACE0F0F;
    send_word(wa);
    check("t2_a_valid", 64'(out_valid), 64'd1);
    check("t2_a_q", 64'(q), 64'(wa));
    send_word(wb);
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    check("t2_full_busy", 64'(busy), 64'd1);
    tick(); tick();
    check("t2_hold_q", 64'(q), 64'(wa));
    check("t2_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_b_q", 64'(q), 64'(wb));
    check("t2_b_valid", 64'(out_valid), 64'd1);
    check("t2_in_ready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("t2_b_drained", 64'(out_valid), 64'd0);

    // 3: restart on the 10th bit
    wr = 31'h2BADBEEF;
    for (int k = 1; k <= 9; k++) send_bit(1'b1, k == 1);
    check("t3_no_err_yet", 64'(err), 64'd0);
    send_bit(wr[1], 1'b1);
    check("t3_err", 64'(err), 64'd1);
    for (int k = 2; k <= M; k++) begin
      send_bit(wr[k], 1'b0);
      if (k == 2) check("t3_err_one_cycle", 64'(err), 64'd0);
    end
    check("t3_valid", 64'(out_valid), 64'd1);
    check("t3_q", 64'(q), 64'(wr));
    tick();

    // 4: stray coefficient in IDLE
    send_bit(1'b1, 1'b0);
    check("t4_err", 64'(err), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_no_valid", 64'(out_valid), 64'd0);
    tick();
    check("t4_err_clear", 64'(err), 64'd0);

    // 5: reset after 20 bits, bit presented during reset is ignored
    for (int k = 1; k <= 20; k++) send_bit(1'b0, k == 1);
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_start = 1'b1;
    #1;
    check("t5_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0; in_start = 1'b0;
    check("t5_q", 64'(q), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_err", 64'(err), 64'd0);
    send_word(wa);
    check("t5_fresh_valid", 64'(out_valid), 64'd1);
    check("t5_fresh_q", 64'(q), 64'(wa));
    tick();

    // 6: random gaps and random backpressure
    fork
      begin
        logic [1:M] w;
        for (int f = 0; f < NF; f++) begin
          w = M'($urandom());
          expq.push_back(w);
          for (int k = 1; k <= M; k++) begin
            while ($urandom_range(0, 1) == 1) tick();
            send_bit(w[k], k == 1);
          end
        end
      end
      begin
        int got = 0;
        int cycles = 0;
        logic [1:M] e;
        while (got < NF && cycles < 60000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              check("t6_unexpected_word", 64'(q), 64'd0 - 64'd1);
            end else begin
              e = expq.pop_front();
              check("t6_word", 64'(q), 64'(e));
            end
            got++;
          end
          tick();
          cycles++;
        end
        check("t6_count", 64'(got), 64'(NF));
        out_ready = 1'b1;
        tick();
        check("t6_final_drained", 64'(out_valid), 64'd0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
